// File: rtl/regfile_mp.sv
// Multi-read-port register file: 0-cycle reads, 1-edge writes, optional zero reg and write bypass.
// A DEPTH-cycle clear engine runs after reset or on io_clear; io_busy high means writes drop and reads return 0.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AW-1:0]       io_rd_addr,
    input  logic                io_rd_wen,
    input  logic [XLEN-1:0]     io_rd_data,
    input  logic [NRD*AW-1:0]   io_rs_addr,
    output logic [NRD*XLEN-1:0] io_rs_data,
    input  logic                io_clear,
    output logic                io_busy
);

    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  CLEAR   = 1'b1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

    logic [0:0]      state_q, state_d;
    logic [AW:0]     ptr_q, ptr_d;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic wr_addr_ok;
    assign wr_addr_ok = ({1'b0, io_rd_addr} < DEPTH_W) &&
                        !((ZERO_REG != 0) && (io_rd_addr == '0));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_waddr = io_rd_addr;
        mem_wdata = io_rd_data;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q[AW-1:0];
            mem_wdata = '0;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == LAST_W) begin
                state_d = IDLE;
            end
        end else begin
            // a write that coincides with io_clear still lands; the clear wipes it afterwards
            mem_we = io_rd_wen && wr_addr_ok;
            if (io_clear) begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // storage has no reset; the clear engine is the only zeroing path
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign io_busy = (state_q == CLEAR);

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;
        assign ra = io_rs_addr[g*AW +: AW];
        always_comb begin
            rv = '0;
            if ((state_q == IDLE) && ({1'b0, ra} < DEPTH_W) &&
                !((ZERO_REG != 0) && (ra == '0))) begin
                if ((BYPASS != 0) && io_rd_wen && (ra == io_rd_addr)) begin
                    rv = io_rd_data;
                end else begin
                    rv = mem_q[ra];
                end
            end
        end
        assign io_rs_data[g*XLEN +: XLEN] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: four instances cover bypass/no-bypass, zero-reg on/off and a 24-deep 3-port file.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus for the three 32-deep, 2-port instances
    logic        rst = 1'b1;
    logic [4:0]  waddr = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [9:0]  rs_addr = '0;
    logic        clr = 1'b0;
    logic [63:0] rs_a, rs_b, rs_c;
    logic        busy_a, busy_b, busy_c;

    // stimulus for the 24-deep, 3-port instance
    logic        rst_d = 1'b1;
    logic [4:0]  waddr_d = '0;
    logic        wen_d = 1'b0;
    logic [31:0] wdata_d = '0;
    logic [14:0] rs_addr_d = '0;
    logic        clr_d = 1'b0;
    logic [95:0] rs_d;
    logic        busy_d;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.XLEN(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(rst), .io_rd_addr(waddr), .io_rd_wen(wen), .io_rd_data(wdata),
        .io_rs_addr(rs_addr), .io_rs_data(rs_a), .io_clear(clr), .io_busy(busy_a));

    regfile_mp #(.XLEN(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .reset(rst), .io_rd_addr(waddr), .io_rd_wen(wen), .io_rd_data(wdata),
        .io_rs_addr(rs_addr), .io_rs_data(rs_b), .io_clear(clr), .io_busy(busy_b));

    regfile_mp #(.XLEN(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_REG(0), .BYPASS(1)) u_c (
        .clk(clk), .reset(rst), .io_rd_addr(waddr), .io_rd_wen(wen), .io_rd_data(wdata),
        .io_rs_addr(rs_addr), .io_rs_data(rs_c), .io_clear(clr), .io_busy(busy_c));

    regfile_mp #(.XLEN(32), .DEPTH(24), .AW(5), .NRD(3), .ZERO_REG(1), .BYPASS(1)) u_d (
        .clk(clk), .reset(rst_d), .io_rd_addr(waddr_d), .io_rd_wen(wen_d), .io_rd_data(wdata_d),
        .io_rs_addr(rs_addr_d), .io_rs_data(rs_d), .io_clear(clr_d), .io_busy(busy_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt_a = 0;
        int cnt_d = 0;
        int guard = 0;
        rst = 1'b1;
        rst_d = 1'b1;
        rs_addr = {5'd31, 5'd5};
        repeat (3) tick();
        checks++;
        if (busy_a !== 1'b1 || rs_a !== 64'h0) begin
            errors++;
            $display("FAIL reset_hold busy=%b rs=%h required busy=1 rs=0", busy_a, rs_a);
        end
        rst = 1'b0;
        rst_d = 1'b0;
        #1;
        while ((busy_a || busy_d) && guard < 200) begin
            if (busy_a) cnt_a++;
            if (busy_d) cnt_d++;
            checks++;
            if (rs_a !== 64'h0 || rs_b !== 64'h0) begin
                errors++;
                $display("FAIL reset_clear_read a=%h b=%h required 0", rs_a, rs_b);
            end
            guard++;
            tick();
        end
        checks++;
        if (cnt_a != 32) begin
            errors++;
            $display("FAIL reset_busy_cycles got %0d required 32", cnt_a);
        end
        checks++;
        if (cnt_d != 24) begin
            errors++;
            $display("FAIL reset_busy_cycles_d24 got %0d required 24", cnt_d);
        end
        checks++;
        if (rs_a !== 64'h0 || rs_c !== 64'h0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_after a=%h c=%h busy_b=%b required 0", rs_a, rs_c, busy_b);
        end
    endtask

    task automatic test_write_read();
        wen = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
        rs_addr = {5'd5, 5'd5};
        #1;
        checks++;
        if (rs_b !== 64'h0) begin
            errors++;
            $display("FAIL nobypass_same_cycle got %h required 0", rs_b);
        end
        checks++;
        if (rs_a[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_x5 got %h required deadbeef", rs_a[31:0]);
        end
        tick();
        wen = 1'b0;
        #1;
        checks++;
        if (rs_b !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL nobypass_next_cycle got %h required deadbeefdeadbeef", rs_b);
        end
    endtask

    task automatic test_bypass();
        wen = 1'b1;
        waddr = 5'd7;
        wdata = 32'h12345678;
        rs_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (rs_a !== {32'h12345678, 32'h12345678}) begin
            errors++;
            $display("FAIL bypass_both_ports got %h required 1234567812345678", rs_a);
        end
        checks++;
        if (rs_b !== 64'h0) begin
            errors++;
            $display("FAIL nobypass_x7_old got %h required 0", rs_b);
        end
        tick();
        wen = 1'b0;
    endtask

    task automatic test_zero_reg();
        wen = 1'b1;
        waddr = 5'd0;
        wdata = 32'hFFFFFFFF;
        rs_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rs_a !== 64'h0) begin
            errors++;
            $display("FAIL zero_reg_bypass got %h required 0", rs_a);
        end
        tick();
        wen = 1'b0;
        #1;
        checks++;
        if (rs_a !== 64'h0 || rs_b !== 64'h0) begin
            errors++;
            $display("FAIL zero_reg_after a=%h b=%h required 0", rs_a, rs_b);
        end
        checks++;
        if (rs_c !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL x0_writable got %h required ffffffffffffffff", rs_c);
        end
    endtask

    task automatic test_runtime_clear();
        int cnt = 0;
        for (int i = 1; i < 32; i++) begin
            wen = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i);
            tick();
        end
        wen = 1'b0;
        rs_addr = {5'd31, 5'd3};
        #1;
        checks++;
        if (rs_a !== {32'd31, 32'd3}) begin
            errors++;
            $display("FAIL fill_readback got %h required 0000001f00000003", rs_a);
        end
        clr = 1'b1;
        wen = 1'b1;
        waddr = 5'd3;
        wdata = 32'hAA;
        tick();
        clr = 1'b0;
        waddr = 5'd10;
        wdata = 32'h55;
        // writes to x10 keep coming for the whole clear; a mid-clear io_clear must not restart it
        while (busy_a && cnt < 200) begin
            cnt++;
            #1;
            checks++;
            if (rs_a !== 64'h0) begin
                errors++;
                $display("FAIL clear_read_zero cycle %0d got %h required 0", cnt, rs_a);
            end
            clr = (cnt == 5);
            tick();
        end
        wen = 1'b0;
        clr = 1'b0;
        checks++;
        if (cnt != 32) begin
            errors++;
            $display("FAIL clear_busy_cycles got %0d required 32", cnt);
        end
        for (int i = 0; i < 32; i++) begin
            rs_addr = {5'(i), 5'(i)};
            #1;
            checks++;
            if (rs_a !== 64'h0 || rs_b !== 64'h0) begin
                errors++;
                $display("FAIL post_clear x%0d a=%h b=%h required 0", i, rs_a, rs_b);
            end
        end
    endtask

    task automatic test_depth24();
        int cnt = 0;
        wen_d = 1'b1;
        waddr_d = 5'd30;
        wdata_d = 32'hCAFE;
        rs_addr_d = {5'd30, 5'd30, 5'd30};
        #1;
        checks++;
        if (rs_d !== 96'h0) begin
            errors++;
            $display("FAIL oob_bypass got %h required 0", rs_d);
        end
        tick();
        waddr_d = 5'd23;
        wdata_d = 32'h1234;
        tick();
        wen_d = 1'b0;
        rs_addr_d = {5'd23, 5'd30, 5'd14};
        #1;
        checks++;
        if (rs_d !== {32'h1234, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL d24_reads got %h required 00001234 00000000 00000000", rs_d);
        end
        clr_d = 1'b1;
        tick();
        clr_d = 1'b0;
        checks++;
        if (busy_d !== 1'b1) begin
            errors++;
            $display("FAIL clear_latency busy=%b required 1", busy_d);
        end
        repeat (10) tick();
        rst_d = 1'b1;
        tick();
        rst_d = 1'b0;
        while (busy_d && cnt < 200) begin
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 24) begin
            errors++;
            $display("FAIL reset_mid_clear_cycles got %0d required 24", cnt);
        end
        #1;
        checks++;
        if (rs_d !== 96'h0) begin
            errors++;
            $display("FAIL d24_after_clear got %h required 0", rs_d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_runtime_clear();
        test_depth24();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the BA20X core family, succeeding the fixed 31×32 two-read-port file. Adds configurable width, depth and read-port count, optional hardwired zero register, optional write-to-read bypass, and a sequential clear engine that zeroes the array after reset or on request. Sits in the decode stage. Register reads feed the ALU operand muxes; the write port is driven by writeback.

## Interface
- XLEN, 32, data width in bits
- DEPTH, 32, number of architectural registers (2..64)
- AW, 5, address width; must satisfy 2^AW >= DEPTH
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- io_rd_addr  in  AW  write address
- io_rd_wen  in  1  write enable
- io_rd_data  in  XLEN  write data
- io_rs_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- io_rs_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- io_clear  in  1  request a full clear of the array
- io_busy  out  1  clear engine active; the file is unusable while high

## Operation
- The FSM has two states, IDLE and CLEAR. A clear pointer `ptr` is AW+1 bits wide.
- Reset: state becomes CLEAR, ptr becomes 0, io_busy is 1. Reset asserted mid-clear restarts at ptr=0.
- CLEAR, each cycle:
  - write 0 to mem[ptr], then increment ptr;
  - on the cycle ptr==DEPTH-1, transition to IDLE;
  - a clear therefore takes exactly DEPTH cycles.
- In CLEAR:
  - io_rd_wen is ignored and the write is dropped, not queued;
  - io_clear is ignored and does not restart the sequence;
  - every io_rs_data port reads 0.
- IDLE with io_clear=1: transition to CLEAR with ptr=0 on the next edge.
  - A write in the same cycle still commits, then is wiped by the clear.
- Write, IDLE only:
  - when io_rd_wen=1, mem[io_rd_addr] <= io_rd_data at the edge;
  - dropped if io_rd_addr >= DEPTH;
  - dropped if ZERO_REG=1 and io_rd_addr=0.
- Read, combinational, each port independent:
  - 0 if in CLEAR;
  - else 0 if addr >= DEPTH;
  - else 0 if ZERO_REG=1 and addr=0;
  - else, if BYPASS=1 and io_rd_wen=1 and io_rs_addr[i]==io_rd_addr, io_rd_data;
  - else mem[addr].
- With BYPASS=0, a read of the address being written returns the old value; the new value is visible the following cycle.
- Any number of read ports may target the same address simultaneously.
- Storage is distributed RAM: one write port, NRD asynchronous read ports. No reset of the storage itself; the clear engine is the only zeroing path.

## Timing
- Read latency is 0 cycles, combinational from io_rs_addr, io_rd_wen, io_rd_addr and io_rd_data.
- Write latency is 1 edge.
- Reset values: io_busy=1. io_rs_data is 0 on all ports, held while busy.
- io_busy stays high for DEPTH cycles after reset deasserts, then drops to 0 after the edge that clears mem[DEPTH-1].
- io_clear has 1 cycle of latency: io_busy rises at the edge after io_clear is sampled in IDLE.
- io_busy is registered directly from the state, with no combinational path from inputs.

## Test plan
- Reset, defaults: hold reset 3 cycles, release. Required:
  - io_busy=1 for exactly 32 cycles;
  - all reads return 0 during and after the clear.
- Write then read, BYPASS=0: write x5=0xDEADBEEF. Required:
  - a read of x5 in the same cycle returns 0;
  - the read returns 0xDEADBEEF on the next cycle, on both ports.
- Bypass, BYPASS=1: write x7=0x12345678 while port 0 and port 1 both read x7. Required: both ports return 0x12345678 in the same cycle.
- Zero register: write x0=0xFFFFFFFF. Required:
  - with ZERO_REG=1, x0 reads 0, bypass included;
  - with ZERO_REG=0 and DEPTH=32, x0 reads 0xFFFFFFFF next cycle.
- Runtime clear: fill x1..x31 with their index, pulse io_clear with a simultaneous write x3=0xAA. Required:
  - io_busy is high for 32 cycles;
  - writes during the clear are dropped;
  - x3 and every other register then read 0.
- Non-power-of-2 and reset mid-clear: DEPTH=24, NRD=3.
  - Required: a write to address 30 is dropped and a read of 30 returns 0.
  - Required: reset asserted at clear cycle 10 restarts the clear, and io_busy stays high 24 more cycles.
